cla_pipe_addsub: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake.

---
 rtl/cla_pipe_addsub_if.sv | 38 +++
 rtl/cla_pipe_addsub.sv | 182 ++++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_addsub_if.sv
// cla_pipe_addsub_if
//   Operand/result bundle for the pipelined carry-lookahead adder/subtractor.
//   master : producer of operands and consumer of results (execute stage, bench)
//   slave  : the adder itself
// Signals
//   in_valid / in_ready   operand beat handshake
//   a, b                  WIDTH-bit operands
//   sub                   1: a - b, 0: a + b + cin
//   cin                   carry-in for add (ignored on subtract)
//   out_valid / out_ready result beat handshake
//   sum                   WIDTH-bit result, mod 2^WIDTH
//   cout, ovf, zero       carry out of MSB, signed overflow, sum == 0
interface cla_pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub
//   Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
//   The operand is cut into BLOCK-bit lookahead groups; each of the STAGES
//   pipeline stages resolves WIDTH/BLOCK/STAGES consecutive groups, starting
//   from the carry registered by the stage below it.
// Ports
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset; clears every valid, data and flag register
//   bus      cla_pipe_addsub_if.slave (operands in, sum/cout/ovf/zero out)
// Timing
//   in_ready = out_ready | ~out_valid. A beat accepted at edge N reaches the
//   output register at edge N+STAGES-1 (N itself when STAGES == 1).
module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 8,
  parameter int STAGES = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  cla_pipe_addsub_if.slave   bus
);

  localparam int NGRP = (BLOCK > 0) ? WIDTH / BLOCK : 1;
  localparam int GPS  = (STAGES > 0) ? NGRP / STAGES : 1;   // groups per stage
  localparam int SW   = GPS * BLOCK;                        // bits per stage

  generate
    if (BLOCK < 1 || STAGES < 1 || ((BLOCK > 0) ? (WIDTH % BLOCK) : 1) != 0 ||
        STAGES > NGRP || ((STAGES > 0) ? (NGRP % STAGES) : 1) != 0) begin : g_bad_cfg
      $error("cla_pipe_addsub: illegal WIDTH=%0d BLOCK=%0d STAGES=%0d", WIDTH, BLOCK, STAGES);
    end
  endgenerate

  logic adv;

  // Values presented to stage k: index 0 is the raw (pre-inverted) operand
  // beat, index k>0 is the register written by stage k-1.
  logic [WIDTH-1:0] a_st [STAGES];
  logic [WIDTH-1:0] b_st [STAGES];   // already beff
  logic [WIDTH-1:0] s_st [STAGES];   // sum bits finished by lower stages
  logic             c_st [STAGES];   // carry into this stage's slice
  logic             v_st [STAGES];

  // The whole pipe moves in lock-step, so a stall only depends on the
  // output register; in_valid never feeds in_ready.
  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  assign a_st[0] = bus.a;
  assign b_st[0] = bus.sub ? ~bus.b : bus.b;
  assign c_st[0] = bus.sub | bus.cin;
  assign s_st[0] = '0;
  assign v_st[0] = bus.in_valid;

  genvar gi, gj;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [SW-1:0]    a_sl;
      logic [SW-1:0]    b_sl;
      logic [SW-1:0]    s_sl;
      logic [WIDTH-1:0] s_o;
      logic             c_o;

      assign a_sl = a_st[gi][gi*SW +: SW];
      assign b_sl = b_st[gi][gi*SW +: SW];

      for (gj = 0; gj < GPS; gj++) begin : g_grp
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] c;       // carry into each bit of the group
        logic             grp_g;
        logic             grp_p;
        logic             cin_g;
        logic             cout_g;

        assign g = a_sl[gj*BLOCK +: BLOCK] & b_sl[gj*BLOCK +: BLOCK];
        assign p = a_sl[gj*BLOCK +: BLOCK] ^ b_sl[gj*BLOCK +: BLOCK];

        if (gj == 0) begin : g_cin_slice
          assign cin_g = c_st[gi];
        end else begin : g_cin_prev
          assign cin_g = g_grp[gj-1].cout_g;
        end

        // Group generate/propagate depend only on operands, so the group
        // carry-out needs just one AND-OR past the incoming group carry.
        always_comb begin
          grp_g = 1'b0;
          grp_p = 1'b1;
          for (int i = 0; i < BLOCK; i++) begin
            grp_g = g[i] | (p[i] & grp_g);
            grp_p = grp_p & p[i];
          end
        end

        always_comb begin
          logic cr;
          c  = '0;
          cr = cin_g;
          for (int i = 0; i < BLOCK; i++) begin
            c[i] = cr;
            cr   = g[i] | (p[i] & cr);
          end
        end

        assign cout_g                   = grp_g | (grp_p & cin_g);
        assign s_sl[gj*BLOCK +: BLOCK]  = p ^ c;
      end

      assign c_o = g_grp[GPS-1].cout_g;

      always_comb begin
        s_o                = s_st[gi];
        s_o[gi*SW +: SW]   = s_sl;
      end

      if (gi < STAGES - 1) begin : g_mid
        logic [WIDTH-1:0] a_reg;
        logic [WIDTH-1:0] b_reg;
        logic [WIDTH-1:0] s_reg;
        logic             c_reg;
        logic             v_reg;

        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            c_reg <= 1'b0;
            v_reg <= 1'b0;
          end else if (adv) begin
            a_reg <= a_st[gi];
            b_reg <= b_st[gi];
            s_reg <= s_o;
            c_reg <= c_o;
            v_reg <= v_st[gi];
          end
        end

        assign a_st[gi+1] = a_reg;
        assign b_st[gi+1] = b_reg;
        assign s_st[gi+1] = s_reg;
        assign c_st[gi+1] = c_reg;
        assign v_st[gi+1] = v_reg;
      end else begin : g_last
        logic [WIDTH-1:0] sum_reg;
        logic             cout_reg;
        logic             ovf_reg;
        logic             zero_reg;
        logic             valid_reg;
        logic             ovf_next;

        // Overflow: both addends share a sign and the result's sign differs.
        assign ovf_next = (a_st[gi][WIDTH-1] == b_st[gi][WIDTH-1]) &&
                          (s_o[WIDTH-1] != a_st[gi][WIDTH-1]);

        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
            valid_reg <= 1'b0;
          end else if (adv) begin
            sum_reg   <= s_o;
            cout_reg  <= c_o;
            ovf_reg   <= ovf_next;
            zero_reg  <= ~|s_o;
            valid_reg <= v_st[gi];
          end
        end

        assign bus.sum       = sum_reg;
        assign bus.cout      = cout_reg;
        assign bus.ovf       = ovf_reg;
        assign bus.zero      = zero_reg;
        assign bus.out_valid = valid_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub
//   Bench for cla_pipe_addsub: directed corner cases, a stalled stream and a
//   mid-stream reset on a 32/8/2 instance, then randomized handshaking sweeps
//   on 16/4/1, 32/8/4 and 64/8/2 instances against an arithmetic model.
module tb_cla_pipe_addsub;

  typedef logic [66:0] res_t;   // {cout, ovf, zero, sum[63:0]}

  localparam int NVEC = 1000;
  localparam int SW_W [3] = '{16, 32, 64};
  localparam int SW_B [3] = '{4, 8, 8};
  localparam int SW_S [3] = '{1, 4, 2};

  logic clk = 1'b0;
  logic rst_n;
  int   chk_cnt = 0;
  int   err_cnt = 0;
  bit   sweep_go = 1'b0;

  always #5 clk = ~clk;

  cla_pipe_addsub_if #(.WIDTH(32)) mif ();
  cla_pipe_addsub #(.WIDTH(32), .BLOCK(8), .STAGES(2)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (mif)
  );

  function automatic res_t pack_res(input logic c, input logic o, input logic z, input logic [63:0] s);
    return {c, o, z, s};
  endfunction

  // Plain arithmetic: {cout,sum} = a + beff + c0, truncated to w bits.
  function automatic res_t ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input logic sub, input logic cin);
    logic [64:0] mask, full;
    logic [63:0] am, beff, s;
    logic        c0, ov;
    mask = (65'd1 << w) - 65'd1;
    am   = a & mask[63:0];
    beff = (sub ? ~b : b) & mask[63:0];
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, am} + {1'b0, beff} + {64'd0, c0};
    s    = full[63:0] & mask[63:0];
    ov   = (am[w-1] == beff[w-1]) && (s[w-1] != am[w-1]);
    return pack_res(full[w], ov, (s == 64'd0), s);
  endfunction

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] v, mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = '0;
      2:       v = 64'd1 << (w - 1);
      3:       v = (64'd1 << (w - 1)) - 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & mask;
  endfunction

  task automatic check(input string tag, input res_t got, input res_t exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic directed(input string tag, input logic [31:0] da, input logic [31:0] db,
                          input logic ds, input logic dc, input res_t exp);
    @(negedge clk);
    mif.a = da; mif.b = db; mif.sub = ds; mif.cin = dc;
    mif.in_valid = 1'b1; mif.out_ready = 1'b1;
    #1 check({tag, " in_ready"}, res_t'(mif.in_ready), res_t'(1'b1));
    @(negedge clk);
    // Scramble the operand bus: the accepted beat must not notice.
    mif.in_valid = 1'b0; mif.a = $urandom; mif.b = $urandom; mif.sub = ~ds; mif.cin = ~dc;
    #1 check({tag, " latency"}, res_t'(mif.out_valid), res_t'(1'b0));
    @(negedge clk);
    #1;
    check({tag, " valid"}, res_t'(mif.out_valid), res_t'(1'b1));
    check(tag, pack_res(mif.cout, mif.ovf, mif.zero, 64'(mif.sum)), exp);
    check({tag, " model"}, pack_res(mif.cout, mif.ovf, mif.zero, 64'(mif.sum)),
          ref_model(32, 64'(da), 64'(db), ds, dc));
  endtask

  // Randomized sweeps over other parameter sets, each with its own scoreboard.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sw
      localparam int W = SW_W[gi];
      bit done = 1'b0;

      cla_pipe_addsub_if #(.WIDTH(W)) sif ();
      cla_pipe_addsub #(.WIDTH(W), .BLOCK(SW_B[gi]), .STAGES(SW_S[gi])) dut_sw (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (sif)
      );

      initial begin
        res_t        exp_q[$];
        res_t        exp_v;
        logic [63:0] op_a, op_b;
        logic        op_s, op_c;
        int          sent, got, cyc;
        sif.in_valid = 1'b0; sif.a = '0; sif.b = '0; sif.sub = 1'b0; sif.cin = 1'b0;
        sif.out_ready = 1'b0;
        sent = 0; got = 0; cyc = 0;
        op_a = rnd_op(W); op_b = rnd_op(W);
        op_s = 1'($urandom_range(0, 1)); op_c = 1'($urandom_range(0, 1));
        wait (sweep_go);
        while (got < NVEC && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          sif.in_valid  = (sent < NVEC) && ($urandom_range(0, 4) != 0);
          sif.a = op_a[W-1:0]; sif.b = op_b[W-1:0]; sif.sub = op_s; sif.cin = op_c;
          sif.out_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (sif.out_valid && sif.out_ready) begin
            if (exp_q.size() == 0) begin
              check($sformatf("sw%0d unexpected beat", W), res_t'(1'b1), res_t'(1'b0));
            end else begin
              exp_v = exp_q.pop_front();
              check($sformatf("sw%0d/%0d/%0d beat %0d", W, SW_B[gi], SW_S[gi], got),
                    pack_res(sif.cout, sif.ovf, sif.zero, 64'(sif.sum)), exp_v);
            end
            got++;
          end
          if (sif.in_valid && sif.in_ready) begin
            exp_q.push_back(ref_model(W, op_a, op_b, op_s, op_c));
            sent++;
            op_a = rnd_op(W); op_b = rnd_op(W);
            op_s = 1'($urandom_range(0, 1)); op_c = 1'($urandom_range(0, 1));
          end
        end
        check($sformatf("sw%0d result count", W), res_t'(got), res_t'(NVEC));
        done = 1'b1;
      end
    end
  endgenerate

  initial begin
    res_t        exp_q[$];
    res_t        exp_v;
    logic [63:0] xa, xb;
    logic        xs, xc;
    int          sent, got, cyc;
    bit          seen;

    rst_n = 1'b0;
    mif.in_valid = 1'b0; mif.a = '0; mif.b = '0; mif.sub = 1'b0; mif.cin = 1'b0;
    mif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset sum/flags", pack_res(mif.cout, mif.ovf, mif.zero, 64'(mif.sum)), '0);
    check("reset out_valid", res_t'(mif.out_valid), res_t'(1'b0));
    check("reset in_ready", res_t'(mif.in_ready), res_t'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    directed("add ffffffff+1", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, pack_res(1'b1, 1'b0, 1'b1, 64'h0));
    directed("add 7fffffff+1", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, pack_res(1'b0, 1'b1, 1'b0, 64'h8000_0000));
    directed("sub 80000000-1", 32'h8000_0000, 32'h1, 1'b1, 1'b0, pack_res(1'b1, 1'b1, 1'b0, 64'h7FFF_FFFF));
    directed("sub 5-7",        32'h5,         32'h7, 1'b1, 1'b0, pack_res(1'b0, 1'b0, 1'b0, 64'hFFFF_FFFE));
    directed("sub 7-7 cin1",   32'h7,         32'h7, 1'b1, 1'b1, pack_res(1'b1, 1'b0, 1'b1, 64'h0));
    directed("add 1234+fff+1", 32'h1234,      32'hFFF, 1'b0, 1'b1, pack_res(1'b0, 1'b0, 1'b0, 64'h2234));

    // Stream of 16 beats with the consumer stalled on cycles 3..6.
    sent = 0; got = 0; cyc = 0;
    xa = rnd_op(32); xb = rnd_op(32);
    xs = 1'($urandom_range(0, 1)); xc = 1'($urandom_range(0, 1));
    while (got < 16 && cyc < 100) begin
      @(negedge clk);
      mif.out_ready = !(cyc >= 3 && cyc <= 6);
      mif.in_valid  = (sent < 16);
      mif.a = xa[31:0]; mif.b = xb[31:0]; mif.sub = xs; mif.cin = xc;
      #1;
      check($sformatf("stream in_ready cyc %0d", cyc), res_t'(mif.in_ready),
            res_t'(!(cyc >= 3 && cyc <= 6)));
      if (mif.out_valid && mif.out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream unexpected beat", res_t'(1'b1), res_t'(1'b0));
        end else begin
          exp_v = exp_q.pop_front();
          check($sformatf("stream beat %0d", got),
                pack_res(mif.cout, mif.ovf, mif.zero, 64'(mif.sum)), exp_v);
        end
        got++;
      end
      if (mif.in_valid && mif.in_ready) begin
        exp_q.push_back(ref_model(32, xa, xb, xs, xc));
        sent++;
        xa = rnd_op(32); xb = rnd_op(32);
        xs = 1'($urandom_range(0, 1)); xc = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    check("stream result count", res_t'(got), res_t'(16));
    mif.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 check("stream drained", res_t'(mif.out_valid), res_t'(1'b0));
    end

    // Two beats in flight, then an asynchronous reset between edges.
    @(negedge clk);
    mif.out_ready = 1'b1; mif.in_valid = 1'b1;
    mif.a = $urandom; mif.b = $urandom; mif.sub = 1'b0; mif.cin = 1'b1;
    @(negedge clk);
    mif.a = $urandom; mif.b = $urandom; mif.sub = 1'b1;
    @(negedge clk);
    mif.in_valid = 1'b0;
    #1 check("pre-reset out_valid", res_t'(mif.out_valid), res_t'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", res_t'(mif.out_valid), res_t'(1'b0));
    check("async reset sum/flags", pack_res(mif.cout, mif.ovf, mif.zero, 64'(mif.sum)), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xa = rnd_op(32); xb = rnd_op(32); xs = 1'b1; xc = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      mif.in_valid = (i == 0);
      mif.a = xa[31:0]; mif.b = xb[31:0]; mif.sub = xs; mif.cin = xc;
      #1;
      if (mif.out_valid) begin
        check("first beat after reset", pack_res(mif.cout, mif.ovf, mif.zero, 64'(mif.sum)),
              ref_model(32, xa, xb, xs, xc));
        seen = 1'b1;
      end
    end
    check("output seen after reset", res_t'(seen), res_t'(1'b1));
    mif.in_valid = 1'b0;

    sweep_go = 1'b1;
    for (int i = 0; i < 30000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); i++)
      @(negedge clk);
    check("sweeps finished", res_t'(g_sw[0].done && g_sw[1].done && g_sw[2].done), res_t'(1'b1));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
